// File: rtl/adpll_lock_det_if.sv
// rtl/adpll_lock_det_if.sv - signal bundle between the adpll lock detector and its environment
interface adpll_lock_det_if #(
   parameter int ERR_W = 10
);
   logic             i_rf;
   logic             i_gen;
   logic [ERR_W-1:0] o_err;
   logic             o_err_vld;
   logic             o_lock;
   logic             o_slip;
   logic             o_timeout;

   modport master (
      output i_rf, i_gen,
      input  o_err, o_err_vld, o_lock, o_slip, o_timeout
   );

   modport slave (
      input  i_rf, i_gen,
      output o_err, o_err_vld, o_lock, o_slip, o_timeout
   );
endinterface

// File: rtl/adpll_lock_det.sv
// rtl/adpll_lock_det.sv - phase error measurement and lock detection between rf and adpll gen edges
module adpll_lock_det #(
   parameter int ERR_W      = 10,
   parameter int MAX_CNT    = 511,
   parameter int TOL        = 4,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input logic              i_clk,
   input logic              i_rst,
   adpll_lock_det_if.slave  bus
);
   localparam int CW = ERR_W - 1;
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);

   typedef enum logic [1:0] {IDLE, WAIT_GEN, WAIT_RF} state_t;

   logic [2:0]       rf_sh, gen_sh;
   logic             rf_rise, gen_rise;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ERR_W-1:0] elapsed;
   logic             meas_vld, meas_neg, slip_ev, tout_ev;
   logic [ERR_W-1:0] meas_mag, meas_err;
   logic             good_ev, bad_ev;
   logic [GW-1:0]    good_q, good_nxt;
   logic [BW-1:0]    bad_q, bad_nxt;
   logic [ERR_W-1:0] err_q;
   logic             err_vld_q, lock_q, slip_q, tout_q;

   // Two sync flops plus one history flop; the rise pulse is registered so both paths share latency
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rf_sh    <= '0;
         gen_sh   <= '0;
         rf_rise  <= 1'b0;
         gen_rise <= 1'b0;
      end else begin
         rf_sh    <= {rf_sh[1:0], bus.i_rf};
         gen_sh   <= {gen_sh[1:0], bus.i_gen};
         rf_rise  <= rf_sh[1] & ~rf_sh[2];
         gen_rise <= gen_sh[1] & ~gen_sh[2];
      end
   end

   // cnt holds cycles since the opening edge minus one
   assign elapsed = {1'b0, cnt_q} + ERR_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      meas_vld = 1'b0;
      meas_neg = 1'b0;
      meas_mag = '0;
      slip_ev  = 1'b0;
      tout_ev  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rf_rise && gen_rise) begin
               meas_vld = 1'b1;
            end else if (rf_rise) begin
               state_d = WAIT_GEN;
               cnt_d   = '0;
            end else if (gen_rise) begin
               state_d = WAIT_RF;
               cnt_d   = '0;
            end
         end
         WAIT_GEN: begin
            cnt_d = cnt_q + CW'(1);
            if (gen_rise) begin
               meas_vld = 1'b1;
               meas_mag = elapsed;
               if (rf_rise) cnt_d = '0;
               else         state_d = IDLE;
            end else if (rf_rise) begin
               slip_ev = 1'b1;
               cnt_d   = '0;
            end else if (elapsed == ERR_W'(MAX_CNT)) begin
               tout_ev = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         WAIT_RF: begin
            cnt_d = cnt_q + CW'(1);
            if (rf_rise) begin
               meas_vld = 1'b1;
               meas_neg = 1'b1;
               meas_mag = elapsed;
               if (gen_rise) cnt_d = '0;
               else          state_d = IDLE;
            end else if (gen_rise) begin
               slip_ev = 1'b1;
               cnt_d   = '0;
            end else if (elapsed == ERR_W'(MAX_CNT)) begin
               tout_ev = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Magnitude is kept separately from the signed result so |err| never overflows
   assign meas_err = meas_neg ? (ERR_W'(0) - meas_mag) : meas_mag;
   assign good_ev  = meas_vld && (meas_mag <= ERR_W'(TOL));
   assign bad_ev   = (meas_vld && !good_ev) || slip_ev || tout_ev;
   assign good_nxt = (good_q == GW'(LOCK_CNT))   ? good_q : good_q + GW'(1);
   assign bad_nxt  = (bad_q  == BW'(UNLOCK_CNT)) ? bad_q  : bad_q  + BW'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         err_q     <= '0;
         err_vld_q <= 1'b0;
         slip_q    <= 1'b0;
         tout_q    <= 1'b0;
         lock_q    <= 1'b0;
         good_q    <= '0;
         bad_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_vld_q <= meas_vld;
         slip_q    <= slip_ev;
         tout_q    <= tout_ev;
         if (meas_vld) err_q <= meas_err;
         if (good_ev) begin
            good_q <= good_nxt;
            bad_q  <= '0;
            if (good_nxt == GW'(LOCK_CNT)) lock_q <= 1'b1;
         end else if (bad_ev) begin
            bad_q  <= bad_nxt;
            good_q <= '0;
            if (bad_nxt == BW'(UNLOCK_CNT)) lock_q <= 1'b0;
         end
      end
   end

   assign bus.o_err     = err_q;
   assign bus.o_err_vld = err_vld_q;
   assign bus.o_slip    = slip_q;
   assign bus.o_timeout = tout_q;
   assign bus.o_lock    = lock_q;
endmodule

// File: tb/tb_adpll_lock_det.sv
// tb/tb_adpll_lock_det.sv - scoreboard bench for adpll_lock_det with an edge-pairing reference model
`timescale 1ns/1ps
module tb_adpll_lock_det;
   localparam int ERR_W = 10, MAX_CNT = 511, TOL = 4, LOCK_CNT = 16, UNLOCK_CNT = 4;
   localparam int LAT = 4;
   localparam int W   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adpll_lock_det_if #(.ERR_W(ERR_W)) bus ();

   adpll_lock_det #(
      .ERR_W(ERR_W), .MAX_CNT(MAX_CNT), .TOL(TOL),
      .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   typedef struct {
      int kind;
      int err;
      bit lock;
      int at;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_vld = 0, n_slip = 0, n_tout = 0;
   bit   mon_lock = 0;
   int   last_err = 0;

   int   pend = 0;
   int   t0 = 0;
   int   good_n = 0, bad_n = 0;
   bit   mlock = 0;
   bit   prev_rf = 0, prev_gen = 0;

   task automatic chk(string name, int act, int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic emit(int kind, int e, int c);
      exp_t x;
      if (kind == 0 && e <= TOL && e >= -TOL) begin
         bad_n = 0;
         if (good_n < LOCK_CNT) good_n++;
         if (good_n == LOCK_CNT) mlock = 1;
      end else begin
         good_n = 0;
         if (bad_n < UNLOCK_CNT) bad_n++;
         if (bad_n == UNLOCK_CNT) mlock = 0;
      end
      x.kind = kind;
      x.err  = e;
      x.lock = mlock;
      x.at   = c + LAT;
      q.push_back(x);
   endtask

   // pend: 0 nothing open, 1 rf edge waiting for gen, 2 gen edge waiting for rf
   task automatic model_step(bit rr, bit gr, int c);
      case (pend)
         0: begin
            if (rr && gr)  emit(0, 0, c);
            else if (rr) begin pend = 1; t0 = c; end
            else if (gr) begin pend = 2; t0 = c; end
         end
         1: begin
            if (gr) begin
               emit(0, c - t0, c);
               if (rr) t0 = c; else pend = 0;
            end else if (rr) begin
               emit(1, 0, c); t0 = c;
            end else if (c - t0 == MAX_CNT) begin
               emit(2, 0, c); pend = 0;
            end
         end
         default: begin
            if (rr) begin
               emit(0, -(c - t0), c);
               if (gr) t0 = c; else pend = 0;
            end else if (gr) begin
               emit(1, 0, c); t0 = c;
            end else if (c - t0 == MAX_CNT) begin
               emit(2, 0, c); pend = 0;
            end
         end
      endcase
   endtask

   task automatic tick(bit rv, bit gv);
      @(posedge clk);
      #1;
      bus.i_rf  = rv;
      bus.i_gen = gv;
      if (!rst) model_step(rv && !prev_rf, gv && !prev_gen, cyc);
      prev_rf  = rv;
      prev_gen = gv;
   endtask

   task automatic do_reset(int n, bit toggle);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      pend = 0; good_n = 0; bad_n = 0; mlock = 0;
      mon_lock = 0; last_err = 0;
      for (int i = 0; i < n; i++) begin
         if (toggle && i < n - 1) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else                     tick(1'b0, 1'b0);
      end
      chk("rst_err",     int'(bus.o_err), 0);
      chk("rst_err_vld", bus.o_err_vld, 0);
      chk("rst_lock",    bus.o_lock, 0);
      chk("rst_slip",    bus.o_slip, 0);
      chk("rst_timeout", bus.o_timeout, 0);
      rst = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
   endtask

   // rf pulse at offset a, gen pulse at offset b (b<0: no gen), each W cycles wide
   task automatic periods(int p, int a, int b, int n, int jit);
      int bb;
      for (int k = 0; k < n; k++) begin
         bb = b;
         if (b >= 0 && jit > 0) begin
            bb = b + int'($urandom_range(0, 2 * jit)) - jit;
            if (bb < 0) bb = 0;
            if (bb > p - W - 1) bb = p - W - 1;
         end
         for (int c = 0; c < p; c++)
            tick(c >= a && c < a + W, b >= 0 && c >= bb && c < bb + W);
      end
   endtask

   always @(negedge clk) begin
      int   np;
      int   kind;
      exp_t e;
      if (!rst) begin
         while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            chk("missing_pulse", cyc, e.at);
            mon_lock = e.lock;
         end
         np = int'(bus.o_err_vld) + int'(bus.o_slip) + int'(bus.o_timeout);
         if (np > 1) begin
            chk("multi_pulse", np, 1);
         end else if (np == 1) begin
            kind = bus.o_err_vld ? 0 : (bus.o_slip ? 1 : 2);
            if (kind == 0) n_vld++; else if (kind == 1) n_slip++; else n_tout++;
            if (q.size() == 0) begin
               chk("unexpected_pulse", kind, -1);
            end else begin
               e = q.pop_front();
               chk("pulse_kind", kind, e.kind);
               chk("pulse_cycle", cyc, e.at);
               if (kind == 0) begin
                  chk("err", int'($signed(bus.o_err)), e.err);
                  last_err = e.err;
               end else begin
                  chk("err_hold", int'($signed(bus.o_err)), last_err);
               end
               mon_lock = e.lock;
            end
         end
         chk("lock", bus.o_lock, mon_lock);
      end
   end

   initial begin
      int s0, v0, t0c, p, a, b;
      bus.i_rf  = 1'b0;
      bus.i_gen = 1'b0;

      do_reset(4, 1'b1);
      idle(20);

      periods(256, 0, 3, 15, 0);
      chk("t2_lock_after15", bus.o_lock, 0);
      periods(256, 0, 3, 1, 0);
      chk("t2_lock_after16", bus.o_lock, 1);
      chk("t2_err", int'($signed(bus.o_err)), 3);

      do_reset(1, 1'b0);
      periods(256, 2, 0, 15, 0);
      chk("t3_lock_after15", bus.o_lock, 0);
      chk("t3_err_raw", int'(bus.o_err), 'h3FE);
      periods(256, 2, 0, 1, 0);
      chk("t3_lock_after16", bus.o_lock, 1);
      periods(256, 5, 5, 2, 0);
      chk("t3_err_same", int'($signed(bus.o_err)), 0);

      periods(256, 0, 20, 3, 0);
      chk("t4_lock_3bad", bus.o_lock, 1);
      chk("t4_err", int'($signed(bus.o_err)), 20);
      periods(256, 0, 20, 1, 0);
      chk("t4_lock_4bad", bus.o_lock, 0);
      periods(256, 0, 3, 15, 0);
      chk("t4_lock_15good", bus.o_lock, 0);
      periods(256, 0, 3, 1, 0);
      chk("t4_lock_16good", bus.o_lock, 1);

      s0 = n_slip; v0 = n_vld; t0c = n_tout;
      periods(256, 0, -1, 8, 0);
      chk("t5_slips", n_slip - s0, 7);
      chk("t5_no_vld", n_vld - v0, 0);
      chk("t5_lock", bus.o_lock, 0);
      periods(700, 0, -1, 1, 0);
      chk("t5_timeouts", n_tout - t0c, 1);

      periods(256, 0, 3, 16, 0);
      chk("t6_locked", bus.o_lock, 1);
      for (int i = 0; i < W; i++) tick(1'b1, 1'b0);
      idle(20);
      do_reset(1, 1'b0);
      idle(10);
      for (int i = 0; i < 13; i++) tick(i >= 5, i < W);
      idle(20);
      chk("t6_err", int'($signed(bus.o_err)), -5);
      chk("t6_lock", bus.o_lock, 0);

      for (int r = 0; r < 6; r++) begin
         p = int'($urandom_range(40, 300));
         a = int'($urandom_range(0, p - W - 1));
         b = int'($urandom_range(0, p - W - 1));
         periods(p, a, b, int'($urandom_range(3, 10)), int'($urandom_range(0, 6)));
      end
      for (int i = 0; i < 3000; i++)
         tick(prev_rf  ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0),
              prev_gen ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0));
      idle(600);
      chk("queue_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
